// File: rtl/somador_serial_param_pkg.sv
// somador_serial_param_pkg: shared state encoding and majority helper for the serial adder
package somador_serial_param_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction
endpackage

// File: rtl/soma_bit_cell.sv
// soma_bit_cell: combinational 1-bit full adder
module soma_bit_cell
  import somador_serial_param_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = maj(a, b, carry_in);
endmodule

// File: rtl/somador_serial_param.sv
// somador_serial_param: bit-serial LSB-first adder/subtractor with start/done handshake
module somador_serial_param
  import somador_serial_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             c, s, cy;
  logic [CW-1:0]    cnt;
  soma_bit_cell u_cell (.a(a_sh[0]), .b(b_sh[0]), .carry_in(c), .sum(s), .carry_out(cy));
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
  // FSM: capture operands on accepted start, then one full-adder step per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b ^ {WIDTH{sub}};
          c     <= carry_in ^ sub;
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          sum  <= {s, sum[WIDTH-1:1]};
          c    <= cy;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            overflow  <= c ^ cy;
            carry_out <= cy;
            cnt       <= '0;
            state     <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
